// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory watchdog.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal instructions fault instead of retiring as NOPs).
module multicycle_control_fsm #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               zero_f,
    input  logic               ovf_f,
    input  logic               neg_f,
    input  logic               carry_f,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_iaddr,
    output logic [1:0]         mem_size,
    output logic               ext_sign,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_b,
    output logic [2:0]         imm_sel,
    output logic [1:0]         result_src,
    output logic               reg_write,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         state_o
);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(10);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : {TO_W{1'b0}};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
    } cls_t;

    state_t                state_q, state_d;
    logic [TO_W-1:0]       wd_q, wd_d;
    logic [1:0]            fcode_q, fcode_d;
    cls_t                  cls_s;
    logic [ALUOP_W-1:0]    alu_op_s;
    logic                  alu_src_b_s;
    logic [2:0]            imm_sel_s;
    logic                  req_s, wait_s, expire_s, taken_s;

    wire [6:0] opcode_s = instr[6:0];
    wire [2:0] funct3_s = instr[14:12];
    wire [6:0] funct7_s = instr[31:25];

    function automatic logic [ALUOP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [ALUOP_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // carry_f is the adder carry-out of rs1 - rs2, so 1 means no borrow (rs1 >= rs2 unsigned)
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic v,
                                          input logic n, input logic c);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = n ^ v;
            3'b101:  t = ~(n ^ v);
            3'b110:  t = ~c;
            3'b111:  t = c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Instruction class and datapath selects from the latched instruction
    always_comb begin
        cls_s       = C_ILL;
        alu_op_s    = ALU_ADD;
        alu_src_b_s = 1'b1;
        imm_sel_s   = IMM_I;
        case (opcode_s)
            OP_REG: begin
                alu_src_b_s = 1'b0;
                alu_op_s    = alu_from_f3(funct3_s, funct7_s[5]);
                if ((funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
                    cls_s = C_ALU;
                end else begin
                    cls_s = C_ILL;
                end
            end
            OP_IMM: begin
                alu_op_s = alu_from_f3(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
                if (funct3_s == 3'b001) begin
                    cls_s = (funct7_s == 7'b0000000) ? C_ALU : C_ILL;
                end else if (funct3_s == 3'b101) begin
                    cls_s = ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) ? C_ALU : C_ILL;
                end else begin
                    cls_s = C_ALU;
                end
            end
            OP_LUI: begin
                cls_s     = C_ALU;
                alu_op_s  = ALU_PASSB;
                imm_sel_s = IMM_U;
            end
            OP_LOAD: begin
                cls_s = ((funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11)) ? C_ILL : C_LOAD;
            end
            OP_STORE: begin
                imm_sel_s = IMM_S;
                cls_s     = (funct3_s[2] || (funct3_s[1:0] == 2'b11)) ? C_ILL : C_STORE;
            end
            OP_BRANCH: begin
                alu_src_b_s = 1'b0;
                alu_op_s    = ALU_SUB;
                imm_sel_s   = IMM_B;
                cls_s       = (funct3_s[2:1] == 2'b01) ? C_ILL : C_BRANCH;
            end
            OP_JAL: begin
                imm_sel_s = IMM_J;
                cls_s     = C_JAL;
            end
            OP_JALR: begin
                cls_s = (funct3_s == 3'b000) ? C_JALR : C_ILL;
            end
            default: cls_s = C_ILL;
        endcase
    end

    assign req_s    = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_s   = req_s && !mem_ready;
    // A handshake in the last allowed cycle wins over the timeout
    assign expire_s = (TIMEOUT != 0) && wait_s && (wd_q == TO_LAST);
    assign taken_s  = branch_taken(funct3_s, zero_f, ovf_f, neg_f, carry_f);

    // State, watchdog and fault-code registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wd_q    <= {TO_W{1'b0}};
            fcode_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            fcode_q <= fcode_d;
        end
    end

    // Next-state and watchdog logic
    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        if ((TIMEOUT != 0) && wait_s) begin
            wd_d = wd_q + TO_W'(1);
        end else begin
            wd_d = {TO_W{1'b0}};
        end
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expire_s) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == C_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_FAULT;
                    fcode_d = FC_ILLEGAL;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_ALU:            state_d = S_WB;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_s == C_STORE) ? S_FETCH : S_WB;
                end else if (expire_s) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes, requests and state-dependent selects; all strobes held low while rst is high
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_iaddr  = 1'b1;
        mem_size   = 2'b10;
        ext_sign   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        result_src = 2'b00;
        reg_write  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_EXEC: begin
                    case (cls_s)
                        C_BRANCH: begin
                            pc_we  = taken_s;
                            pc_sel = 2'b01;
                        end
                        C_JAL: begin
                            pc_we      = 1'b1;
                            pc_sel     = 2'b01;
                            reg_write  = 1'b1;
                            result_src = 2'b10;
                        end
                        C_JALR: begin
                            pc_we      = 1'b1;
                            pc_sel     = 2'b10;
                            reg_write  = 1'b1;
                            result_src = 2'b10;
                        end
                        default: pc_we = 1'b0;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_iaddr = 1'b0;
                    mem_we    = (cls_s == C_STORE);
                    mem_size  = funct3_s[1:0];
                    ext_sign  = ~funct3_s[2];
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    result_src = (cls_s == C_LOAD) ? 2'b01 : 2'b00;
                end
                default: mem_req = 1'b0;
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    assign alu_op     = alu_op_s;
    assign alu_src_b  = alu_src_b_s;
    assign imm_sel    = imm_sel_s;
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fcode_q;
    assign state_o    = state_q;

endmodule
